// File: rtl/conv_pkg.sv
// conv_pkg: shared sizes, scheduler states and input-interface command encodings
package conv_pkg;
  localparam int CONV_IMAGE_SIZE  = 8;
  localparam int CONV_KERNEL_SIZE = 3;
  localparam int CONV_MAC_LATENCY = 4;
  localparam int OUT_ROWS         = CONV_IMAGE_SIZE - CONV_KERNEL_SIZE + 1;
  localparam int CONV_ARRAY_SIZE  = OUT_ROWS;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MAC   = 3'd2,
    S_SHIFT = 3'd3,
    S_DRAIN = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6,
    S_FLUSH = 3'd7
  } conv_state_e;
  localparam logic [1:0] CMD_NOP      = 2'b00;
  localparam logic [1:0] CMD_LOAD_ROW = 2'b01;
  localparam logic [1:0] CMD_SHIFT    = 2'b10;
  localparam logic [1:0] CMD_FLUSH    = 2'b11;
endpackage

// File: rtl/conv_sched_loop_cnt.sv
// conv_sched_loop_cnt: nested kernel-column / kernel-row / output-row counters with last flags
module conv_sched_loop_cnt #(
  parameter int K = 3,
  parameter int R = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       kc_inc_i,
  input  logic       kr_inc_i,
  input  logic       row_inc_i,
  output logic [1:0] kc_o,
  output logic [1:0] kr_o,
  output logic [2:0] row_o,
  output logic       kc_last_o,
  output logic       kr_last_o,
  output logic       row_last_o
);
  logic [1:0] kc_q, kc_d, kr_q, kr_d;
  logic [2:0] row_q, row_d;
  // a kernel-row step restarts the column walk; an output-row step restarts the whole kernel walk
  always_comb begin
    kc_d  = (clr_i || kr_inc_i || row_inc_i) ? 2'd0 : kc_inc_i ? kc_q + 2'd1 : kc_q;
    kr_d  = (clr_i || row_inc_i) ? 2'd0 : kr_inc_i ? kr_q + 2'd1 : kr_q;
    row_d = clr_i ? 3'd0 : row_inc_i ? row_q + 3'd1 : row_q;
  end
  // counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      kc_q  <= 2'd0;
      kr_q  <= 2'd0;
      row_q <= 3'd0;
    end else begin
      kc_q  <= kc_d;
      kr_q  <= kr_d;
      row_q <= row_d;
    end
  end
  assign kc_o       = kc_q;
  assign kr_o       = kr_q;
  assign row_o      = row_q;
  assign kc_last_o  = kc_q == 2'(K - 1);
  assign kr_last_o  = kr_q == 2'(K - 1);
  assign row_last_o = row_q == 3'(R - 1);
endmodule

// File: rtl/conv_layer_scheduler.sv
// conv_layer_scheduler: sequences window loads, kernel shifts, MACs, drain and row hand-off for one image.
// Optional perf counters are built when CONV_SCHED_PERF_EN is defined.
module conv_layer_scheduler
  import conv_pkg::*;
#(
  parameter int IMAGE_SIZE  = CONV_IMAGE_SIZE,
  parameter int KERNEL_SIZE = CONV_KERNEL_SIZE,
  parameter int ARRAY_SIZE  = CONV_ARRAY_SIZE,
  parameter int MAC_LATENCY = CONV_MAC_LATENCY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [1:0]  input_interface_cmd,
  input  logic [1:0]  input_interface_ack,
  output logic [2:0]  row_addr,
  output logic [3:0]  weight_addr,
  output logic        mac_en,
  output logic        acc_clr,
  output logic        feature_valid,
  input  logic        feature_ready,
  output logic [2:0]  out_row,
  output logic [2:0]  current_state
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0] perf_busy_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);
  localparam int DW = $clog2(MAC_LATENCY + 1);
  if (ARRAY_SIZE != IMAGE_SIZE - KERNEL_SIZE + 1) begin : g_cfg_err
    $error("conv_layer_scheduler: ARRAY_SIZE must equal IMAGE_SIZE-KERNEL_SIZE+1");
  end
  conv_state_e   state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [1:0]    kc, kr;
  logic          kc_last, kr_last, row_last, ack_ok, drain_last, start_acc;
  assign input_interface_cmd = (state_q == S_LOAD)  ? CMD_LOAD_ROW :
                               (state_q == S_SHIFT) ? CMD_SHIFT :
                               (state_q == S_FLUSH) ? CMD_FLUSH : CMD_NOP;
  assign ack_ok     = input_interface_cmd != CMD_NOP && input_interface_ack == input_interface_cmd;
  assign drain_last = drain_q == DW'(MAC_LATENCY - 1);
  assign start_acc  = state_q == S_IDLE && start;
  // next state: commands wait for their matching ack, MAC walks the kernel, WRITE waits for downstream
  always_comb begin
    state_d = state_q;
    drain_d = (state_q == S_DRAIN) ? drain_q + DW'(1) : '0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  if (ack_ok) state_d = S_MAC;
      S_MAC:   state_d = !kc_last ? S_SHIFT : !kr_last ? S_LOAD : S_DRAIN;
      S_SHIFT: if (ack_ok) state_d = S_MAC;
      S_DRAIN: if (drain_last) state_d = S_WRITE;
      S_WRITE: if (feature_ready) state_d = row_last ? S_FLUSH : S_LOAD;
      S_FLUSH: if (ack_ok) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  // state and drain-timer registers
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end
  conv_sched_loop_cnt #(
    .K(KERNEL_SIZE),
    .R(ARRAY_SIZE)
  ) u_loop_cnt (
    .clk       (clk),
    .rst       (rst_n),
    .clr_i     (start_acc),
    .kc_inc_i  (state_q == S_MAC && !kc_last),
    .kr_inc_i  (state_q == S_MAC && kc_last && !kr_last),
    .row_inc_i (state_q == S_WRITE && feature_ready && !row_last),
    .kc_o      (kc),
    .kr_o      (kr),
    .row_o     (out_row),
    .kc_last_o (kc_last),
    .kr_last_o (kr_last),
    .row_last_o(row_last)
  );
  assign busy          = state_q != S_IDLE;
  assign done          = state_q == S_DONE;
  assign row_addr      = (state_q == S_LOAD) ? out_row + {1'b0, kr} : 3'd0;
  assign weight_addr   = (state_q == S_MAC) ? 4'(kr) * 4'(KERNEL_SIZE) + 4'(kc) : 4'd0;
  assign mac_en        = state_q == S_MAC;
  assign acc_clr       = state_q == S_LOAD && kr == 2'd0;
  assign feature_valid = state_q == S_WRITE;
  assign current_state = state_q;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0] busy_cnt_q, stall_cnt_q;
  logic        stall;
  assign stall = ((state_q == S_LOAD || state_q == S_SHIFT || state_q == S_FLUSH) && !ack_ok) ||
                 (state_q == S_WRITE && !feature_ready);
  // busy and stall cycle counters, restarted with each accepted image
  always_ff @(posedge clk) begin
    if (rst_n || start_acc) begin
      busy_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_cnt_q  <= busy_cnt_q + 32'(busy);
      stall_cnt_q <= stall_cnt_q + 32'(stall);
    end
  end
  assign perf_busy_cnt  = busy_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_conv_layer_scheduler.sv
// tb_conv_layer_scheduler: directed and randomized image runs against a loop-level reference model
module tb_conv_layer_scheduler;
  import conv_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic        busy, done, mac_en, acc_clr, fv, fr;
  logic [1:0]  cmd, ack;
  logic [2:0]  row_addr, out_row, cur_state;
  logic [3:0]  weight_addr;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0] perf_busy, perf_stall;
`endif
  int checks = 0, failures = 0;
  int wait_cnt = 0, fv_cnt = 0, ack_delay = 0, fix_delay = 0, delay_sum = 0;
  bit rnd_ack = 1'b0, wrong_ack = 1'b0;
  int fr_stall[8] = '{default: 0};

  always #5 clk = ~clk;

  conv_layer_scheduler dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .busy               (busy),
    .done               (done),
    .input_interface_cmd(cmd),
    .input_interface_ack(ack),
    .row_addr           (row_addr),
    .weight_addr        (weight_addr),
    .mac_en             (mac_en),
    .acc_clr            (acc_clr),
    .feature_valid      (fv),
    .feature_ready      (fr),
`ifdef CONV_SCHED_PERF_EN
    .perf_busy_cnt      (perf_busy),
    .perf_stall_cnt     (perf_stall),
`endif
    .out_row            (out_row),
    .current_state      (cur_state)
  );

  // responder: acks the pending command after ack_delay wait cycles, releases ready after a per-row stall
  always @* begin
    ack = (cmd != CMD_NOP && wait_cnt >= ack_delay) ?
          ((wrong_ack && cmd == CMD_LOAD_ROW) ? CMD_SHIFT : cmd) : CMD_NOP;
    fr = fv_cnt >= fr_stall[out_row];
  end

  always @(posedge clk) begin
    if (rst_n) begin
      wait_cnt <= 0;
      fv_cnt   <= 0;
    end else begin
      wait_cnt <= (cmd != CMD_NOP && ack != cmd) ? wait_cnt + 1 : 0;
      fv_cnt   <= (fv && !fr) ? fv_cnt + 1 : 0;
    end
    if (cmd == CMD_NOP) ack_delay <= rnd_ack ? int'($urandom_range(0, 3)) : fix_delay;
    if (cmd != CMD_NOP && ack == cmd) delay_sum <= delay_sum + ack_delay;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int qdiff(input int a[$], input int b[$]);
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] != b[i]) return i;
    return (a.size() == b.size()) ? -1 : ((a.size() < b.size()) ? a.size() : b.size());
  endfunction

  // one image: model walks rows/kernel rows/columns; exp_busy < 0 derives the total from applied waits
  task automatic run_image(input string tag, input int exp_busy, input int mid_at, input bit on_done);
    int wq[$], ewq[$], lq[$], elq[$], fq[$], efq[$];
    int busy_n = 0, done_n = 0, d0 = delay_sum, stall_sum = 0, idle_n = 0, first_busy = 0;
    bit fin = 1'b0;
    for (int r = 0; r < OUT_ROWS; r++) begin
      stall_sum += fr_stall[r];
      for (int kr = 0; kr < 3; kr++) begin
        elq.push_back((r + kr) * 2 + ((kr == 0) ? 1 : 0));
        for (int kc = 0; kc < 3; kc++) ewq.push_back(kr * 3 + kc);
      end
      for (int s = 0; s <= fr_stall[r]; s++) efq.push_back(r);
    end
    @(negedge clk) start = 1'b1;
    for (int c = 0; c < 2000 && !fin; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 0) first_busy = int'(busy);
      if (!busy) fin = 1'b1;
      else begin
        busy_n++;
        if (mac_en) wq.push_back(int'(weight_addr));
        if (cmd == CMD_LOAD_ROW && ack == CMD_LOAD_ROW) lq.push_back(int'(row_addr) * 2 + int'(acc_clr));
        if (fv) fq.push_back(int'(out_row));
        if (done) begin
          done_n++;
          if (on_done) start = 1'b1;
        end
        if (c == mid_at) start = 1'b1;
      end
    end
    chk({tag, "_finished"}, int'(fin), 1);
    repeat (3) begin
      @(negedge clk);
      idle_n += int'(busy) + int'(done);
    end
    chk({tag, "_busy_next"}, first_busy, 1);
    chk({tag, "_busy_cycles"}, busy_n, (exp_busy >= 0) ? exp_busy : 140 + (delay_sum - d0) + stall_sum);
    chk({tag, "_done_pulses"}, done_n, 1);
    chk({tag, "_mac_count"}, wq.size(), 54);
    chk({tag, "_weight_seq_diff_at"}, qdiff(wq, ewq), -1);
    chk({tag, "_load_seq_diff_at"}, qdiff(lq, elq), -1);
    chk({tag, "_valid_seq_diff_at"}, qdiff(fq, efq), -1);
    chk({tag, "_idle_after"}, idle_n, 0);
  endtask

  initial begin
    int found = 0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'({busy, done, cmd, row_addr, weight_addr, mac_en, acc_clr, fv, out_row}), 0);
    chk("reset_state", int'(cur_state), 0);
    rst_n = 1'b0;
    run_image("zero_wait", 140, -1, 1'b0);
    fix_delay = 2;
    run_image("ack_delay2", 250, -1, 1'b0);
    fix_delay = 0;
    fr_stall[2] = 10;
    run_image("ready_stall", 150, -1, 1'b0);
`ifdef CONV_SCHED_PERF_EN
    chk("perf_stall", int'(perf_stall), 10);
    chk("perf_busy", int'(perf_busy), 150);
`endif
    fr_stall[2] = 0;
    run_image("start_ignored", 140, 50, 1'b1);
    rnd_ack = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < OUT_ROWS; r++) fr_stall[r] = int'($urandom_range(0, 3));
      run_image("random", -1, -1, 1'b0);
    end
    rnd_ack = 1'b0;
    for (int r = 0; r < 8; r++) fr_stall[r] = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < 1000 && found == 0; c++) begin
      if (out_row == 3'd3 && mac_en) found = 1;
      else @(negedge clk);
    end
    chk("reset_mac_row3_reached", found, 1);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    chk("midrun_reset_outputs", int'({busy, done, cmd, row_addr, weight_addr, mac_en, acc_clr, fv, out_row}), 0);
    chk("midrun_reset_state", int'(cur_state), 0);
    run_image("after_reset", 140, -1, 1'b0);
    wrong_ack = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("wrong_ack_hold_state_cmd", int'({cur_state, cmd}), int'({S_LOAD, CMD_LOAD_ROW}));
      @(negedge clk);
    end
    wrong_ack = 1'b0;
    @(negedge clk);
    chk("wrong_ack_then_mac", int'({cur_state, mac_en, weight_addr}), int'({S_MAC, 1'b1, 4'd0}));
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
